// File: rtl/sv32_ptw_pkg.sv
// Shared types and constants for the Sv32 page-table walker.
package ptw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_L1   = 2'd1,
      ST_L0   = 2'd2,
      ST_RESP = 2'd3
   } ptw_state_e;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   localparam int PTE_PPN_LSB = 10;
   localparam int PAGE_OFFSET = 12;
   localparam int LEVELS      = 2;

   // Word address of a PTE: ({ppn,12'b0} + vpn*4) >> 2 is simply {ppn, vpn}.
   function automatic logic [31:0] pte_word_addr(input logic [21:0] ppn, input logic [9:0] vpn);
      return {ppn, vpn};
   endfunction

endpackage

// File: rtl/sv32_ptw_if.sv
// Request/response handshake between the TLB miss path and the walker.
interface sv32_ptw_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_vaddr;
   logic [21:0] req_satp_ppn;

   logic        resp_valid;
   logic        resp_ready;
   logic        resp_fault;
   logic        resp_level;
   logic [31:0] resp_pte;
   logic [33:0] resp_paddr;

   // Requester side (TLB miss path)
   modport master (
      output req_valid, req_vaddr, req_satp_ppn, resp_ready,
      input  req_ready, resp_valid, resp_fault, resp_level, resp_pte, resp_paddr
   );

   // Walker side
   modport slave (
      input  req_valid, req_vaddr, req_satp_ppn, resp_ready,
      output req_ready, resp_valid, resp_fault, resp_level, resp_pte, resp_paddr
   );

endinterface

// File: rtl/sv32_ptw_pte_check.sv
// Combinational classification of a fetched PTE at a given walk level.
module ptw_pte_check
   import ptw_pkg::*;
(
   input  logic [31:0] pte,
   input  logic        level,     // 1 = first-level table, 0 = second-level
   output logic        is_leaf,
   output logic        is_fault
);

   logic invalid;
   logic misaligned;

   assign invalid    = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
   assign is_leaf    = pte[PTE_R] | pte[PTE_X];
   // A superpage leaf must have ppn0 clear, otherwise it is not 4 MiB aligned.
   assign misaligned = level && is_leaf && (pte[PTE_PPN_LSB +: 10] != 10'd0);
   // A pointer in the last level has nowhere left to go.
   assign is_fault   = invalid || misaligned || (!level && !is_leaf);

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: two-level read-only walk over dmem port 2.
module sv32_ptw
   import ptw_pkg::*;
#(
   parameter int DATA_WHITH = 32,
   parameter int ADDR_WHITH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   sv32_ptw_if.slave             bus,
   output logic [ADDR_WHITH-1:0] ptw_addr,
   input  logic [DATA_WHITH-1:0] ptw_rdata,
   input  logic                  mem_wen_busy
);

   ptw_state_e  state_reg;
   logic [21:0] vaddr_low_reg;    // vpn0 + page offset; vpn1 is consumed at accept
   logic [31:0] pte_waddr_reg;    // PTE physical address >> 2, zero outside L1/L0
   logic        resp_valid_reg;
   logic        resp_fault_reg;
   logic        resp_level_reg;
   logic [31:0] resp_pte_reg;
   logic [33:0] resp_paddr_reg;

   logic [31:0] pte;
   logic        at_l1;
   logic        access_fault;
   logic        is_leaf;
   logic        is_fault;

   assign pte          = ptw_rdata;
   assign at_l1        = (state_reg == ST_L1);
   // PTE lies outside the memory reachable through ptw_addr.
   assign access_fault = |pte_waddr_reg[31:ADDR_WHITH];
   assign ptw_addr     = pte_waddr_reg[ADDR_WHITH-1:0];

   assign bus.req_ready  = (state_reg == ST_IDLE) && !flush;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_fault = resp_fault_reg;
   assign bus.resp_level = resp_level_reg;
   assign bus.resp_pte   = resp_pte_reg;
   assign bus.resp_paddr = resp_paddr_reg;

   ptw_pte_check u_check (
      .pte      (pte),
      .level    (at_l1),
      .is_leaf  (is_leaf),
      .is_fault (is_fault)
   );

   // Walk FSM with registered address and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         vaddr_low_reg  <= '0;
         pte_waddr_reg  <= '0;
         resp_valid_reg <= 1'b0;
         resp_fault_reg <= 1'b0;
         resp_level_reg <= 1'b0;
         resp_pte_reg   <= '0;
         resp_paddr_reg <= '0;
      end else if (flush) begin
         state_reg      <= ST_IDLE;
         pte_waddr_reg  <= '0;
         resp_valid_reg <= 1'b0;
         resp_fault_reg <= 1'b0;
         resp_level_reg <= 1'b0;
         resp_pte_reg   <= '0;
         resp_paddr_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  vaddr_low_reg <= bus.req_vaddr[21:0];
                  pte_waddr_reg <= pte_word_addr(bus.req_satp_ppn, bus.req_vaddr[31:22]);
                  state_reg     <= ST_L1;
               end
            end
            ST_L1, ST_L0: begin
               if (access_fault) begin
                  // No read is issued; there is no PTE to report.
                  state_reg      <= ST_RESP;
                  pte_waddr_reg  <= '0;
                  resp_valid_reg <= 1'b1;
                  resp_fault_reg <= 1'b1;
                  resp_level_reg <= at_l1;
                  resp_pte_reg   <= '0;
                  resp_paddr_reg <= '0;
               end else if (!mem_wen_busy) begin
                  if (is_fault) begin
                     state_reg      <= ST_RESP;
                     pte_waddr_reg  <= '0;
                     resp_valid_reg <= 1'b1;
                     resp_fault_reg <= 1'b1;
                     resp_level_reg <= at_l1;
                     resp_pte_reg   <= pte;
                     resp_paddr_reg <= '0;
                  end else if (is_leaf) begin
                     state_reg      <= ST_RESP;
                     pte_waddr_reg  <= '0;
                     resp_valid_reg <= 1'b1;
                     resp_fault_reg <= 1'b0;
                     resp_level_reg <= at_l1;
                     resp_pte_reg   <= pte;
                     resp_paddr_reg <= at_l1 ? {pte[31:20], vaddr_low_reg}
                                             : {pte[31:PTE_PPN_LSB], vaddr_low_reg[PAGE_OFFSET-1:0]};
                  end else begin
                     // Pointer PTE (only reachable in L1): descend one level.
                     pte_waddr_reg <= pte_word_addr(pte[31:PTE_PPN_LSB], vaddr_low_reg[21:12]);
                     state_reg     <= ST_L0;
                  end
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  state_reg      <= ST_IDLE;
                  resp_valid_reg <= 1'b0;
                  resp_fault_reg <= 1'b0;
                  resp_level_reg <= 1'b0;
                  resp_pte_reg   <= '0;
                  resp_paddr_reg <= '0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
